// File: rtl/mux_rr.sv
`default_nettype none
// ============================================================================
// mux_rr : N-channel registered multiplexer, valid/ready, fixed-pri or RR arb
// Rev 1.0
// ============================================================================
module mux_rr #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int RR_MODE = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH*WIDTH-1:0]         in_data,
  input  logic [NUM_CH-1:0]               in_valid,
  output logic [NUM_CH-1:0]               in_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [$clog2(NUM_CH)-1:0]       out_sel,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             xfer;
  int               idx;

  assign load_en = !out_valid || out_ready;
  assign xfer    = rst_n && load_en && grant_vld;

  // Search order starts just past the last granted channel in round-robin mode.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) begin
        idx = (int'(last) + 1 + k) % NUM_CH;
      end else begin
        idx = k;
      end
      if (!grant_vld && in_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant == SEL_W'(k)) begin
        grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready[k] = xfer && (grant == SEL_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_data  <= grant_data;
      out_sel   <= grant;
      out_valid <= 1'b1;
      last      <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr.sv
`default_nettype none
// Testbench for mux_rr: vector table on a 4x8 round-robin instance,
// hand sequences for fixed priority and the 2x1 corner.
`timescale 1ns/1ps
module tb_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rr_in_ready, fp_in_ready;
  logic [7:0]  rr_out_data, fp_out_data;
  logic [1:0]  rr_out_sel, fp_out_sel;
  logic        rr_out_valid, fp_out_valid;

  logic [1:0]  n2_in_data, n2_in_valid, n2_in_ready;
  logic        n2_out_ready;
  logic [0:0]  n2_out_data, n2_out_sel;
  logic        n2_out_valid;

  mux_rr #(.NUM_CH(4), .WIDTH(8), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
    .out_valid(rr_out_valid), .out_ready(out_ready));

  mux_rr #(.NUM_CH(4), .WIDTH(8), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
    .out_valid(fp_out_valid), .out_ready(out_ready));

  mux_rr #(.NUM_CH(2), .WIDTH(1), .RR_MODE(1)) dut_n2 (
    .clk(clk), .rst_n(rst_n), .in_data(n2_in_data), .in_valid(n2_in_valid),
    .in_ready(n2_in_ready), .out_data(n2_out_data), .out_sel(n2_out_sel),
    .out_valid(n2_out_valid), .out_ready(n2_out_ready));

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic        ready;
    logic [31:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] D0 = 32'hA3A2A1A0;
  localparam logic [31:0] D1 = 32'hA35CA1A0;
  localparam logic [31:0] D2 = 32'hA36DA1A0;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic o,
                              input logic [31:0] d, input logic [3:0] er,
                              input logic eov, input logic [1:0] es, input logic [7:0] ed);
    vec_t t;
    t.rst_n = r; t.valid = v; t.ready = o; t.data = d;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_sel = es; t.exp_data = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_data = D0; in_valid = 4'hF; out_ready = 1'b1;
    n2_in_data = 2'b10; n2_in_valid = 2'b00; n2_out_ready = 1'b1;

    // reset with all channels requesting
    vecs.push_back(mk(0, 4'hF, 1, D0, 4'h0, 0, 2'd0, 8'h00));
    vecs.push_back(mk(0, 4'hF, 1, D0, 4'h0, 0, 2'd0, 8'h00));
    // round-robin fairness, two full rotations
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 4'hF, 1, D0, 4'(1 << (k % 4)), 1, 2'(k % 4), 8'hA0 + 8'(k % 4)));
    // wrap and skip from last=3, idle drain keeps last
    vecs.push_back(mk(1, 4'b1001, 1, D0, 4'b0001, 1, 2'd0, 8'hA0));
    vecs.push_back(mk(1, 4'b1001, 1, D0, 4'b1000, 1, 2'd3, 8'hA3));
    vecs.push_back(mk(1, 4'b0000, 1, D0, 4'b0000, 0, 2'd3, 8'hA3));
    vecs.push_back(mk(1, 4'b1001, 1, D0, 4'b0001, 1, 2'd0, 8'hA0));
    // back-pressure on channel 2
    vecs.push_back(mk(1, 4'b0100, 1, D1, 4'b0100, 1, 2'd2, 8'h5C));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 4'b0100, 0, D1, 4'b0000, 1, 2'd2, 8'h5C));
    vecs.push_back(mk(1, 4'b0100, 1, D2, 4'b0100, 1, 2'd2, 8'h6D));
    vecs.push_back(mk(1, 4'b0000, 1, D2, 4'b0000, 0, 2'd2, 8'h6D));
    // reset in the middle of a stall
    vecs.push_back(mk(1, 4'b0010, 1, D2, 4'b0010, 1, 2'd1, 8'hA1));
    vecs.push_back(mk(1, 4'b0010, 0, D2, 4'b0000, 1, 2'd1, 8'hA1));
    vecs.push_back(mk(0, 4'b0010, 0, D2, 4'b0000, 0, 2'd0, 8'h00));
    vecs.push_back(mk(1, 4'hF,    1, D0, 4'b0001, 1, 2'd0, 8'hA0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; in_valid = vecs[i].valid;
      out_ready = vecs[i].ready; in_data = vecs[i].data;
      #2;
      chk($sformatf("v%0d in_ready", i), 32'(rr_in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(rr_out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d out_sel", i), 32'(rr_out_sel), 32'(vecs[i].exp_sel));
      chk($sformatf("v%0d out_data", i), 32'(rr_out_data), 32'(vecs[i].exp_data));
    end

    // fixed priority: channel 1 always wins over channel 3
    @(negedge clk); rst_n = 1'b0; in_valid = 4'h0; out_ready = 1'b1; in_data = D0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); rst_n = 1'b1; in_valid = 4'b1010;
      #2 chk("fp in_ready", 32'(fp_in_ready), 32'h2);
      @(posedge clk); #1;
      chk("fp out_sel", 32'(fp_out_sel), 32'd1);
      chk("fp out_data", 32'(fp_out_data), 32'hA1);
      chk("fp out_valid", 32'(fp_out_valid), 32'd1);
    end
    @(negedge clk); in_valid = 4'b1100;
    #2 chk("fp in_ready low2", 32'(fp_in_ready), 32'h4);
    @(posedge clk); #1;
    chk("fp out_sel low2", 32'(fp_out_sel), 32'd2);
    chk("fp out_data low2", 32'(fp_out_data), 32'hA2);

    // two-channel, one-bit instance: alternation and mid-stream reset
    @(negedge clk); in_valid = 4'h0; n2_in_valid = 2'b11; n2_in_data = 2'b10;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      #2 chk("n2 in_ready", 32'(n2_in_ready), 32'(1 << (k % 2)));
      @(posedge clk); #1;
      chk("n2 out_sel", 32'(n2_out_sel), 32'(k % 2));
      chk("n2 out_data", 32'(n2_out_data), 32'(k % 2));
      chk("n2 out_valid", 32'(n2_out_valid), 32'd1);
    end
    @(negedge clk); rst_n = 1'b0;
    #2 chk("n2 in_ready rst", 32'(n2_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("n2 out_valid rst", 32'(n2_out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #2 chk("n2 in_ready post", 32'(n2_in_ready), 32'd1);
    @(posedge clk); #1;
    chk("n2 out_sel post", 32'(n2_out_sel), 32'd0);
    chk("n2 out_valid post", 32'(n2_out_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr.md
# mux_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes and built-in arbitration.
- Generalises the team's two-input 8-bit combinational multiplexers: the select line is replaced by an internal arbiter that picks among requesting channels.
- Sits between several producers and one consumer; the result is held in a single output register.
- Selectable fixed-priority or round-robin policy, 1-cycle latency, full throughput.

## Interface
- NUM_CH, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data width per channel; must be ≥ 1.
- RR_MODE, 1, arbitration policy.
  - 1 = round-robin.
  - 0 = fixed priority, lowest index wins.
- SEL_W, $clog2(NUM_CH), width of the channel index; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  NUM_CH*WIDTH  packed channel data; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel request.
- in_ready  out  NUM_CH  per-channel accept; at most one bit high per cycle.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  index of the channel whose data is in out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.

## Operation
- Definitions:
  - load_en = !out_valid || out_ready.
  - A channel transfer occurs when in_valid[i] && in_ready[i].
  - An output transfer occurs when out_valid && out_ready.
- Grant (combinational, 0 or 1 channel):
  - RR_MODE=0: lowest index i with in_valid[i]=1.
  - RR_MODE=1: first valid index searching upward from (last+1) mod NUM_CH, wrapping. last is a SEL_W-bit register.
- in_ready[i] = load_en && grant==i && in_valid[i]. in_ready is all-zero when no channel is valid or when load_en=0.
- Registered update on a channel transfer (rising edge):
  - out_data ← channel i data.
  - out_sel ← i.
  - out_valid ← 1.
  - last ← i.
- Output drained with no new channel transfer: out_valid ← 1'b0. out_data and out_sel keep their previous values.
- Simultaneous drain and channel transfer: the new word replaces the old one in the same edge and out_valid stays 1. This gives back-to-back throughput of 1 word/cycle.
- Output stalled (out_valid=1, out_ready=0):
  - out_data, out_sel and last are held stable.
  - All in_ready are 0.
  - No channel is lost; requesters keep in_valid high.
- last is updated only on a channel transfer, never on an idle cycle.
- Fairness (RR_MODE=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,…,NUM_CH-1,0,… with no channel skipped.
- Policy is fixed at elaboration; there is no runtime mode switch.

## Timing
- Reset (rst_n=0 sampled at a rising edge), regardless of state:
  - out_valid=0, out_data=0, out_sel=0.
  - last=NUM_CH-1, so channel 0 has first round-robin priority.
  - in_ready is all-zero while rst_n=0.
- Reset mid-stall discards the held word with no output transfer.
- Latency:
  - Channel transfer at edge k → out_valid=1 with the data visible after edge k.
  - Consumer may accept in cycle k+1.
- in_ready depends combinationally on in_valid, out_valid and out_ready. There is no combinational path from in_data to any output.
- Sustained rate is 1 word/cycle while out_ready=1 and at least one channel is valid.
- out_data/out_sel are stable whenever out_valid=1 && out_ready=0.

## Test plan
Use NUM_CH=4, WIDTH=8 unless noted.
1. Reset: drive rst_n=0 for 2 cycles with all in_valid=4'hF.
   - Required: out_valid=0, out_data=8'h00, in_ready=4'h0.
   - After release, first grant is channel 0.
2. Round-robin fairness: RR_MODE=1, in_valid=4'hF, data channel i = 8'hA0+i, out_ready=1 for 8 cycles.
   - Required: out_sel sequence 0,1,2,3,0,1,2,3.
   - Required: out_data A0,A1,A2,A3,A0,…
   - out_valid=1 on every cycle after the first.
3. Fixed priority: RR_MODE=0, in_valid=4'b1010 for 4 cycles.
   - Required: every grant is channel 1, out_data=8'hA1, in_ready=4'b0010.
4. Back-pressure: RR_MODE=1, channel 2 alone valid (8'h5C).
   - Word loaded, then out_ready=0 for 3 cycles.
   - Required during the stall: out_data=8'h5C, out_sel=2, out_valid=1 held, in_ready=4'h0.
   - On out_ready=1, the next word loads in the same cycle.
5. Wrap and skip: RR_MODE=1, last=3, in_valid=4'b1001.
   - Required: grant 0, then 3, then 0.
   - A drain with in_valid=0 drops out_valid to 0 and leaves last unchanged.
6. Parameter corner: NUM_CH=2, WIDTH=1, both channels valid.
   - Required: alternating out_sel 0,1,0,1.
   - Mid-stream rst_n=0 gives out_valid=0, and the next grant is channel 0.
